// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Per-frame scheduler in front of game_logic. On each accepted frame_start it
//   streams obs_count entries of the obstacle buffer (synchronous-read RAM,
//   READ_LATENCY cycles) into game_logic, one per cycle. It then issues exactly
//   one gl_new_frame tick carrying the player inputs latched since the previous
//   tick. It also runs the session: start, play, game over and restart.
//
//   Optional feature macro: PAUSE_EN. When defined, a btn_start rising edge
//   between ticks pauses play (state PAUSED), and a second edge resumes it.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   frame_start                one-cycle pulse per video frame
//   btn_start                  start/restart (and pause) button level
//   btn_duck/jump/left/right   player button levels
//   obs_count                  valid buffer entries, sampled at frame_start
//   obs_addr / obs_data        buffer read port, {type,lane,depth[10:0]}
//   gl_obstacle(_valid)        obstacle stream to game_logic
//   gl_firstrow                streamed obstacle depth < FIRSTROW_DEPTH
//   gl_new_frame               one-cycle game tick
//   gl_duck/jump/left/right    latched inputs, stable through gl_new_frame
//   gl_rst                     reset pulse to game_logic
//   gl_game_over               game over indication from game_logic
//   state                      IDLE=0 SCAN=1 DRAIN=2 TICK=3 OVER=4 PAUSED=5
//   frame_overrun              sticky: frame_start seen while busy
module frame_sequencer #(
  parameter int unsigned MAX_OBS        = 32,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned FIRSTROW_DEPTH = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         btn_start,
  input  logic                         btn_duck,
  input  logic                         btn_jump,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic [$clog2(MAX_OBS+1)-1:0] obs_count,
  output logic [$clog2(MAX_OBS)-1:0]   obs_addr,
  input  logic [15:0]                  obs_data,
  output logic [15:0]                  gl_obstacle,
  output logic                         gl_obstacle_valid,
  output logic                         gl_firstrow,
  output logic                         gl_new_frame,
  output logic                         gl_duck,
  output logic                         gl_jump,
  output logic                         gl_left,
  output logic                         gl_right,
  output logic                         gl_rst,
  input  logic                         gl_game_over,
  output logic [2:0]                   state,
  output logic                         frame_overrun
);

  localparam int unsigned CW = $clog2(MAX_OBS + 1);
  localparam int unsigned AW = $clog2(MAX_OBS);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OBS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRAIN  = 3'd2,
    TICK   = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q;
  logic [AW-1:0]           addr_q;
  logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
  logic                    armed_q, go_q, overrun_q, rst_pulse_q;
  logic                    start_prev_q, left_prev_q, right_prev_q;
  logic                    duck_q, jump_q, left_q, right_q;
  logic                    duck_d, jump_d, left_d, right_d;
  logic                    left_n, right_n;
  logic [15:0]             obstacle_q;
  logic                    valid_q, firstrow_q;
  logic                    start_rise, issue, scan_last, busy;

  assign start_rise = btn_start & ~start_prev_q;
  assign issue      = (state_q == SCAN) && (count_q != '0);
  assign scan_last  = (count_q == '0) || (CW'(addr_q) == count_q - CW'(1));
  assign busy       = (state_q == SCAN) || (state_q == DRAIN) || (state_q == TICK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start && armed_q) state_d = SCAN;
`ifdef PAUSE_EN
        else if (start_rise && armed_q) state_d = PAUSED;
`endif
      end
      SCAN:   if (scan_last) state_d = DRAIN;
      DRAIN:  if (vpipe_q == '0) state_d = TICK;
      TICK:   state_d = (go_q || gl_game_over) ? OVER : IDLE;
      OVER:   if (start_rise) state_d = IDLE;
`ifdef PAUSE_EN
      PAUSED: if (start_rise) state_d = IDLE;
`else
      PAUSED: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gl_new_frame      = (state_q == TICK);
    state             = state_q;
    obs_addr          = addr_q;
    gl_obstacle       = obstacle_q;
    gl_obstacle_valid = valid_q;
    gl_firstrow       = firstrow_q;
    gl_duck           = duck_q;
    gl_jump           = jump_q;
    gl_left           = left_q;
    gl_right          = right_q;
    gl_rst            = rst | rst_pulse_q;
    frame_overrun     = overrun_q;
  end

  // Input latches: the tick cycle clears what was reported but still accepts
  // a press arriving on that same cycle, so it lands in the next frame.
  always_comb begin
    left_n  = ((state_q == TICK) ? 1'b0 : left_q)  | (btn_left  & ~left_prev_q);
    right_n = ((state_q == TICK) ? 1'b0 : right_q) | (btn_right & ~right_prev_q);
    duck_d  = ((state_q == TICK) ? 1'b0 : duck_q)  | btn_duck;
    jump_d  = ((state_q == TICK) ? 1'b0 : jump_q)  | btn_jump;
    left_d  = left_n;
    right_d = right_n & ~left_n;
    if (state_q == PAUSED) begin
      duck_d  = duck_q;
      jump_d  = jump_q;
      left_d  = left_q;
      right_d = right_q;
    end
  end

  always_comb begin
    vpipe_d    = vpipe_q << 1;
    vpipe_d[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      addr_q       <= '0;
      vpipe_q      <= '0;
      armed_q      <= 1'b0;
      go_q         <= 1'b0;
      overrun_q    <= 1'b0;
      rst_pulse_q  <= 1'b0;
      start_prev_q <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      duck_q       <= 1'b0;
      jump_q       <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      obstacle_q   <= '0;
      valid_q      <= 1'b0;
      firstrow_q   <= 1'b0;
    end else begin
      start_prev_q <= btn_start;
      left_prev_q  <= btn_left;
      right_prev_q <= btn_right;
      duck_q       <= duck_d;
      jump_q       <= jump_d;
      left_q       <= left_d;
      right_q      <= right_d;
      vpipe_q      <= vpipe_d;

      // A session starts from unarmed IDLE or restarts from OVER.
      rst_pulse_q <= start_rise && ((state_q == IDLE && !armed_q) || state_q == OVER);
      if (start_rise && ((state_q == IDLE && !armed_q) || state_q == OVER)) armed_q <= 1'b1;

      if (state_q == IDLE && state_d == SCAN)
        count_q <= (obs_count > MAX_CNT) ? MAX_CNT : obs_count;

      addr_q <= (state_q == SCAN && !scan_last) ? addr_q + AW'(1) : '0;

      // Game over is remembered until the current frame's tick has been issued.
      if (state_q == OVER) go_q <= 1'b0;
      else if (gl_game_over && state_q != IDLE) go_q <= 1'b1;

      if (frame_start && busy) overrun_q <= 1'b1;

      valid_q <= vpipe_q[READ_LATENCY-1];
      if (vpipe_q[READ_LATENCY-1]) begin
        obstacle_q <= obs_data;
        firstrow_q <= (obs_data[10:0] < 11'(FIRSTROW_DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  localparam int MAX_OBS = 32;

  logic        clk = 1'b0;
  logic        rst, frame_start, btn_start, btn_duck, btn_jump, btn_left, btn_right;
  logic [5:0]  obs_count;
  logic [4:0]  obs_addr;
  logic [15:0] obs_data, gl_obstacle;
  logic        gl_obstacle_valid, gl_firstrow, gl_new_frame;
  logic        gl_duck, gl_jump, gl_left, gl_right, gl_rst, gl_game_over;
  logic [2:0]  state;
  logic        frame_overrun;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Buffer model: two-cycle synchronous read
  logic [15:0] mem [MAX_OBS];
  logic [4:0]  a_d1;
  logic [15:0] rdata;
  always @(posedge clk) begin
    a_d1  <= obs_addr;
    rdata <= mem[a_d1];
  end
  assign obs_data = rdata;

  always #5 clk = ~clk;

  frame_sequencer #(.MAX_OBS(32), .READ_LATENCY(2), .FIRSTROW_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .btn_start(btn_start),
    .btn_duck(btn_duck), .btn_jump(btn_jump), .btn_left(btn_left), .btn_right(btn_right),
    .obs_count(obs_count), .obs_addr(obs_addr), .obs_data(obs_data),
    .gl_obstacle(gl_obstacle), .gl_obstacle_valid(gl_obstacle_valid),
    .gl_firstrow(gl_firstrow), .gl_new_frame(gl_new_frame),
    .gl_duck(gl_duck), .gl_jump(gl_jump), .gl_left(gl_left), .gl_right(gl_right),
    .gl_rst(gl_rst), .gl_game_over(gl_game_over), .state(state),
    .frame_overrun(frame_overrun)
  );

  // Reference model of the player inputs owed to the next tick
  bit exp_duck, exp_jump, exp_left, exp_right;
  bit cur_d, cur_j, cur_l, cur_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input bit d, input bit j, input bit l, input bit r);
    btn_duck = d; btn_jump = j; btn_left = l; btn_right = r;
    if (d) exp_duck = 1;
    if (j) exp_jump = 1;
    if (l && !cur_l) exp_left = 1;
    if (r && !cur_r) exp_right = 1;
    cur_d = d; cur_j = j; cur_l = l; cur_r = r;
    step();
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MAX_OBS; i++) mem[i] = 16'($urandom);
  endtask

  // One video frame: expected stream is mem[0..min(cnt,32)-1] then one tick.
  task automatic do_frame(input int cnt, input int inject_at, input bit expect_tick);
    logic [15:0] got[$];
    bit          fr_got[$];
    int          n_exp, ticks, valids_at_tick, window;
    bit          e_fr, e_r;
    n_exp = (cnt > MAX_OBS) ? MAX_OBS : cnt;
    ticks = 0;
    valids_at_tick = -1;
    window = n_exp + 30;
    obs_count = 6'(cnt);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int c = 0; c < window; c++) begin
      if (c == inject_at) begin
        vectors++;
        if (state !== 3'd1) begin
          miscompares++;
          $display("FAIL inject_state: got %0d expected 1", state);
        end
        frame_start = 1'b1;
      end
      step();
      frame_start = 1'b0;
      if (gl_obstacle_valid) begin
        got.push_back(gl_obstacle);
        fr_got.push_back(gl_firstrow);
      end
      if (gl_new_frame) begin
        ticks++;
        if (ticks == 1) begin
          valids_at_tick = got.size();
          e_r = exp_right && !exp_left;
          vectors++;
          if ({gl_duck, gl_jump, gl_left, gl_right} !== {exp_duck, exp_jump, exp_left, e_r}) begin
            miscompares++;
            $display("FAIL tick_inputs: got djlr=%b%b%b%b expected %b%b%b%b",
                     gl_duck, gl_jump, gl_left, gl_right, exp_duck, exp_jump, exp_left, e_r);
          end
        end
        exp_duck = cur_d; exp_jump = cur_j; exp_left = 0; exp_right = 0;
      end
    end
    vectors++;
    if (ticks != (expect_tick ? 1 : 0)) begin
      miscompares++;
      $display("FAIL tick_count: got %0d expected %0d", ticks, expect_tick ? 1 : 0);
    end
    vectors++;
    if (got.size() != (expect_tick ? n_exp : 0)) begin
      miscompares++;
      $display("FAIL valid_count: got %0d expected %0d", got.size(), expect_tick ? n_exp : 0);
    end
    if (expect_tick && ticks == 1) begin
      vectors++;
      if (valids_at_tick != got.size()) begin
        miscompares++;
        $display("FAIL valid_after_tick: got %0d before tick, expected %0d", valids_at_tick, got.size());
      end
    end
    if (expect_tick) begin
      for (int i = 0; i < got.size() && i < n_exp; i++) begin
        e_fr = (mem[i][10:0] < 11'd128);
        vectors++;
        if (got[i] !== mem[i] || fr_got[i] !== e_fr) begin
          miscompares++;
          $display("FAIL obstacle[%0d]: got %h fr=%b expected %h fr=%b", i, got[i], fr_got[i], mem[i], e_fr);
        end
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press_start(input bit expect_pulse);
    btn_start = 1'b1;
    step();
    vectors++;
    if (gl_rst !== expect_pulse) begin
      miscompares++;
      $display("FAIL gl_rst_pulse: got %b expected %b", gl_rst, expect_pulse);
    end
    btn_start = 1'b0;
    step();
    vectors++;
    if (gl_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL gl_rst_end: got %b expected 0", gl_rst);
    end
  endtask

  task automatic test_reset();
    frame_start = 0; btn_start = 0; gl_game_over = 0; obs_count = 0;
    btn_duck = 0; btn_jump = 0; btn_left = 0; btn_right = 0;
    fill_mem();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({state, gl_rst, gl_obstacle_valid, gl_new_frame, obs_addr, frame_overrun,
         gl_duck, gl_jump, gl_left, gl_right} !== {3'd0, 1'b1, 2'b00, 5'd0, 5'b0}) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d gl_rst=%b v=%b nf=%b addr=%0d ov=%b in=%b%b%b%b",
               state, gl_rst, gl_obstacle_valid, gl_new_frame, obs_addr, frame_overrun,
               gl_duck, gl_jump, gl_left, gl_right);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (gl_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: gl_rst got %b expected 0", gl_rst);
    end
    do_frame(3, -1, 0);  // session not started yet
  endtask

  task automatic test_start();
    press_start(1'b1);
    check_val("state_after_start", int'(state), 0);
    fill_mem();
    do_frame(3, -1, 1);
  endtask

  task automatic test_firstrow();
    fill_mem();
    mem[0] = {mem[0][15:11], 11'd127};
    mem[1] = {mem[1][15:11], 11'd128};
    mem[2] = {mem[2][15:11], 11'd0};
    mem[3] = {mem[3][15:11], 11'd2047};
    mem[4] = {mem[4][15:11], 11'd129};
    mem[5] = {mem[5][15:11], 11'd126};
    do_frame(6, -1, 1);
  endtask

  task automatic test_lane();
    fill_mem();
    set_buttons(0, 0, 1, 0);
    for (int f = 0; f < 3; f++) do_frame(4, -1, 1);
    set_buttons(0, 0, 0, 0);
    set_buttons(0, 0, 1, 1);
    do_frame(2, -1, 1);
    set_buttons(0, 0, 0, 0);
    set_buttons(0, 0, 0, 1);
    do_frame(2, -1, 1);
    set_buttons(1, 0, 0, 0);
    set_buttons(0, 1, 0, 0);
    do_frame(1, -1, 1);
    do_frame(1, -1, 1);
    set_buttons(0, 0, 0, 0);
    do_frame(1, -1, 1);
  endtask

  task automatic test_overrun();
    check_val("overrun_before", int'(frame_overrun), 0);
    fill_mem();
    do_frame(10, 3, 1);
    check_val("overrun_set", int'(frame_overrun), 1);
    do_frame(2, -1, 1);
    check_val("overrun_sticky", int'(frame_overrun), 1);
  endtask

  task automatic test_random();
    int cnt;
    for (int f = 0; f < 8; f++) begin
      set_buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cnt = (f == 0) ? 0 : (f == 1) ? 40 : (f == 2) ? 32 : int'($urandom_range(0, 40));
      fill_mem();
      do_frame(cnt, -1, 1);
    end
    set_buttons(0, 0, 0, 0);
  endtask

`ifdef PAUSE_EN
  task automatic test_pause();
    press_start(1'b0);
    check_val("state_paused", int'(state), 5);
    for (int f = 0; f < 4; f++) do_frame(3, -1, 0);
    check_val("state_still_paused", int'(state), 5);
    press_start(1'b0);
    check_val("state_resumed", int'(state), 0);
    fill_mem();
    do_frame(3, -1, 1);
  endtask
`else
  task automatic test_start_ignored();
    press_start(1'b0);
    check_val("state_start_in_play", int'(state), 0);
    fill_mem();
    do_frame(2, -1, 1);
  endtask
`endif

  task automatic test_game_over();
    fill_mem();
    gl_game_over = 1'b1;
    do_frame(5, -1, 1);
    check_val("state_over", int'(state), 4);
    for (int f = 0; f < 5; f++) do_frame(4, -1, 0);
    check_val("state_over_held", int'(state), 4);
    gl_game_over = 1'b0;
    press_start(1'b1);
    check_val("state_restart", int'(state), 0);
    fill_mem();
    do_frame(4, -1, 1);
  endtask

  task automatic test_reset_midscan();
    fill_mem();
    obs_count = 6'd20;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    check_val("midscan_state", int'(state), 1);
    rst = 1'b1;
    step();
    check_val("midscan_rst_state", int'(state), 0);
    check_val("midscan_rst_addr", int'(obs_addr), 0);
    check_val("midscan_rst_gl_rst", int'(gl_rst), 1);
    rst = 1'b0;
    exp_duck = 0; exp_jump = 0; exp_left = 0; exp_right = 0;
    step();
    check_val("midscan_valid", int'(gl_obstacle_valid), 0);
    do_frame(3, -1, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_firstrow();
    test_lane();
    test_overrun();
    test_random();
`ifdef PAUSE_EN
    test_pause();
`else
    test_start_ignored();
`endif
    test_game_over();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
